// File: rtl/lp_dmem_ctrl.sv
// Low-power controller in front of a single-port SRAM macro: three-stage access
// pipeline plus a power FSM for light sleep, deep sleep, shutdown and timed wake-up.
module lp_dmem_ctrl #(
  parameter int NUM_BANK = 48,
  parameter int IDLE_CYC = 16,
  parameter int LS_WAKE  = 2,
  parameter int DS_WAKE  = 8,
  parameter int SD_WAKE  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [4:0]              req_addr,
  input  logic [32*NUM_BANK-1:0]  req_wdata,
  output logic                    rsp_valid,
  output logic [32*NUM_BANK-1:0]  rsp_rdata,
  input  logic                    sleep_req,
  input  logic                    shutdown_req,
  output logic [2:0]              pwr_state,
  output logic                    mem_SD,
  output logic                    mem_CE,
  output logic                    mem_WEB,
  output logic                    mem_OEB,
  output logic                    mem_CSB,
  output logic                    mem_DS,
  output logic                    mem_LS,
  output logic [4:0]              mem_A,
  output logic [32*NUM_BANK-1:0]  mem_I,
  input  logic [32*NUM_BANK-1:0]  mem_O
);

  localparam int ICW  = $clog2(IDLE_CYC + 1);
  localparam int WMAX = (SD_WAKE > DS_WAKE) ? ((SD_WAKE > LS_WAKE) ? SD_WAKE : LS_WAKE)
                                            : ((DS_WAKE > LS_WAKE) ? DS_WAKE : LS_WAKE);
  localparam int WCW  = $clog2(WMAX + 1);

  localparam logic [ICW-1:0] IDLE_LIM = ICW'(IDLE_CYC);
  localparam logic [WCW-1:0] LS_LOAD  = WCW'(LS_WAKE);
  localparam logic [WCW-1:0] DS_LOAD  = WCW'(DS_WAKE);
  localparam logic [WCW-1:0] SD_LOAD  = WCW'(SD_WAKE);

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_LSLEEP = 3'd1,
    ST_DSLEEP = 3'd2,
    ST_SHUTDN = 3'd3,
    ST_WAKE   = 3'd4
  } state_t;

  state_t         state_reg, state_next;
  logic [ICW-1:0] idle_cnt_reg, idle_cnt_next;
  logic [WCW-1:0] wake_cnt_reg, wake_load;
  logic           wake_ld_en;
  logic           acc_p1_reg, rd_p1_reg, rd_p2_reg;
  logic           accept, pipe_empty;

  assign req_ready  = !rst && (state_reg == ST_ACTIVE) && !sleep_req && !shutdown_req;
  assign accept     = req_valid && req_ready;
  // The response register counts as the last stage: sleep waits until it has been delivered.
  assign pipe_empty = !acc_p1_reg && !rd_p2_reg && !rsp_valid;
  assign pwr_state  = state_reg;

  always_comb begin
    state_next    = state_reg;
    idle_cnt_next = '0;
    wake_load     = '0;
    wake_ld_en    = 1'b0;
    case (state_reg)
      ST_ACTIVE: begin
        if (accept)
          idle_cnt_next = '0;
        else if (pipe_empty && idle_cnt_reg != IDLE_LIM)
          idle_cnt_next = idle_cnt_reg + 1'b1;
        else
          idle_cnt_next = idle_cnt_reg;
        if (pipe_empty && shutdown_req)
          state_next = ST_SHUTDN;
        else if (pipe_empty && sleep_req)
          state_next = ST_DSLEEP;
        else if (!accept && idle_cnt_next == IDLE_LIM)
          state_next = ST_LSLEEP;
      end
      ST_LSLEEP: begin
        if (req_valid || sleep_req || shutdown_req) begin
          state_next = ST_WAKE;
          wake_load  = LS_LOAD;
          wake_ld_en = 1'b1;
        end
      end
      ST_DSLEEP: begin
        if (shutdown_req) begin
          state_next = ST_SHUTDN;
        end else if (!sleep_req) begin
          state_next = ST_WAKE;
          wake_load  = DS_LOAD;
          wake_ld_en = 1'b1;
        end
      end
      ST_SHUTDN: begin
        if (!shutdown_req) begin
          state_next = ST_WAKE;
          wake_load  = SD_LOAD;
          wake_ld_en = 1'b1;
        end
      end
      ST_WAKE: begin
        // Counter reaches zero on this edge: WAKE lasts exactly the loaded number of cycles.
        if (wake_cnt_reg == WCW'(1) || wake_cnt_reg == '0)
          state_next = ST_ACTIVE;
      end
      default: state_next = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_ACTIVE;
      idle_cnt_reg <= '0;
      wake_cnt_reg <= '0;
      acc_p1_reg   <= 1'b0;
      rd_p1_reg    <= 1'b0;
      rd_p2_reg    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      mem_CSB      <= 1'b1;
      mem_WEB      <= 1'b1;
      mem_OEB      <= 1'b1;
      mem_CE       <= 1'b1;
      mem_SD       <= 1'b0;
      mem_DS       <= 1'b0;
      mem_LS       <= 1'b0;
      mem_A        <= '0;
      mem_I        <= '0;
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
      if (wake_ld_en)
        wake_cnt_reg <= wake_load;
      else if (state_reg == ST_WAKE && wake_cnt_reg != '0)
        wake_cnt_reg <= wake_cnt_reg - 1'b1;

      acc_p1_reg <= accept;
      rd_p1_reg  <= accept && !req_we;
      rd_p2_reg  <= rd_p1_reg;
      rsp_valid  <= rd_p2_reg;
      if (rd_p2_reg)
        rsp_rdata <= mem_O;

      mem_CSB <= !accept;
      mem_WEB <= !(accept && req_we);
      mem_OEB <= !(accept && !req_we);
      if (accept)
        mem_A <= req_addr;
      if (accept && req_we)
        mem_I <= req_wdata;

      // Macro power pins follow the state being entered so they line up with pwr_state.
      mem_CE <= (state_next == ST_ACTIVE);
      mem_LS <= (state_next == ST_LSLEEP);
      mem_DS <= (state_next == ST_DSLEEP);
      mem_SD <= (state_next == ST_SHUTDN);
    end
  end

endmodule

// File: tb/tb_lp_dmem_ctrl.sv
// Bench for lp_dmem_ctrl: SRAM macro model, table-driven vectors, random traffic
// against an array/queue reference, and hand-written power-state sequences.
module tb_lp_dmem_ctrl;
  localparam int NB = 48;
  localparam int DW = 32 * NB;

  logic          clk = 1'b0;
  logic          rst, req_valid, req_we, sleep_req, shutdown_req;
  logic [4:0]    req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [2:0]    pwr_state;
  logic          mem_SD, mem_CE, mem_WEB, mem_OEB, mem_CSB, mem_DS, mem_LS;
  logic [4:0]    mem_A;
  logic [DW-1:0] mem_I, mem_O;

  always #5 clk = ~clk;

  lp_dmem_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sleep_req(sleep_req), .shutdown_req(shutdown_req), .pwr_state(pwr_state),
    .mem_SD(mem_SD), .mem_CE(mem_CE), .mem_WEB(mem_WEB), .mem_OEB(mem_OEB),
    .mem_CSB(mem_CSB), .mem_DS(mem_DS), .mem_LS(mem_LS),
    .mem_A(mem_A), .mem_I(mem_I), .mem_O(mem_O)
  );

  // Synchronous SRAM macro: read data appears the cycle after the select cycle.
  logic [DW-1:0] macro_arr [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) macro_arr[i] <= '0;
    end else if (!mem_CSB) begin
      if (!mem_WEB) macro_arr[mem_A] <= mem_I;
      else if (!mem_OEB) mem_O <= macro_arr[mem_A];
    end
  end

  typedef struct { int due; logic [DW-1:0] data; } sb_t;
  typedef struct { bit we; logic [4:0] addr; logic [31:0] word; logic [31:0] exp; } vec_t;

  sb_t           sb[$];
  logic [DW-1:0] ref_mem [32];
  int            cyc, checks, errors, exp_rdy, last_rsp_cyc, acc_cyc, n;
  bit            p_acc, p_we, tbl_has;
  logic [4:0]    p_addr;
  logic [DW-1:0] p_wdata, tbl_exp;
  vec_t          tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ..%h expected ..%h (low 64 bits, cycle %0d)", nm, act[63:0], exp[63:0], cyc);
    end
  endtask

  // One clock cycle: check outputs against the reference, then record this cycle's handshake.
  task automatic step();
    sb_t e;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chkw("rsp_rdata", rsp_rdata, sb[0].data);
      void'(sb.pop_front());
      last_rsp_cyc = cyc;
    end else begin
      chk("rsp_valid_quiet", 64'(rsp_valid), 64'd0);
    end
    if (p_acc) begin
      chk("mem_access", 64'({mem_CSB, mem_WEB, mem_OEB, mem_A}), 64'({1'b0, ~p_we, p_we, p_addr}));
      if (p_we) chkw("mem_I", mem_I, p_wdata);
    end else begin
      chk("mem_idle", 64'({mem_CSB, mem_WEB, mem_OEB}), 64'(3'b111));
    end
    if (exp_rdy >= 0) chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    p_acc   = req_valid && req_ready;
    p_we    = req_we;
    p_addr  = req_addr;
    p_wdata = req_wdata;
    if (p_acc) begin
      $display("cycle %0d: accept %s addr %0d", cyc, req_we ? "write" : "read", req_addr);
      if (req_we) begin
        ref_mem[req_addr] = req_wdata;
      end else begin
        e.due  = cyc + 3;
        e.data = tbl_has ? tbl_exp : ref_mem[req_addr];
        sb.push_back(e);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; req_valid = 1'b0; sleep_req = 1'b0; shutdown_req = 1'b0; exp_rdy = 0;
    sb.delete();
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    repeat (cycles) step();
    rst = 1'b0;
    exp_rdy = 1;
  endtask

  task automatic check_reset_vals();
    chk("rst_pwr_state", 64'(pwr_state), 64'd0);
    chk("rst_mem_ctl", 64'({mem_CSB, mem_WEB, mem_OEB, mem_CE, mem_SD, mem_DS, mem_LS}), 64'(7'b1111000));
    chk("rst_mem_A", 64'(mem_A), 64'd0);
    chkw("rst_mem_I", mem_I, '0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chkw("rst_rsp_rdata", rsp_rdata, '0);
  endtask

  task automatic idle(input int cycles);
    req_valid = 1'b0;
    repeat (cycles) step();
  endtask

  initial begin
    int gap;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    sleep_req = 1'b0; shutdown_req = 1'b0;
    cyc = 0; checks = 0; errors = 0; exp_rdy = 0; last_rsp_cyc = -1;
    p_acc = 0; p_we = 0; p_addr = '0; p_wdata = '0; tbl_has = 0; tbl_exp = '0;
    tbl[0] = '{1'b1, 5'd5, 32'hA5A5A5A5, 32'h0};
    tbl[1] = '{1'b1, 5'd0, 32'h11111111, 32'h0};
    tbl[2] = '{1'b1, 5'd1, 32'h22222222, 32'h0};
    tbl[3] = '{1'b1, 5'd2, 32'h33333333, 32'h0};
    tbl[4] = '{1'b0, 5'd5, 32'h0,        32'hA5A5A5A5};
    tbl[5] = '{1'b0, 5'd0, 32'h0,        32'h11111111};
    tbl[6] = '{1'b0, 5'd1, 32'h0,        32'h22222222};
    tbl[7] = '{1'b0, 5'd2, 32'h0,        32'h33333333};
    @(negedge clk);

    do_reset(3);
    check_reset_vals();

    // Idle entry into light sleep after 16 quiet cycles, then wake on a request.
    for (int i = 0; i < 16; i++) begin
      chk("idle_active", 64'(pwr_state), 64'd0);
      step();
    end
    chk("ls_state", 64'(pwr_state), 64'd1);
    chk("ls_pins", 64'({mem_LS, mem_CE, mem_DS, mem_SD}), 64'(4'b1000));
    exp_rdy = 0; req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("ls_wake_state", 64'(pwr_state), 64'd4);
      chk("ls_wake_pins", 64'({mem_LS, mem_CE, mem_DS, mem_SD}), 64'(4'b0000));
      step();
    end
    chk("ls_back_active", 64'(pwr_state), 64'd0);
    chk("ls_back_ce", 64'(mem_CE), 64'd1);
    exp_rdy = 1;
    step();
    idle(4);

    // Table vectors: back-to-back writes then reads of the same words.
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = tbl[i].we; req_addr = tbl[i].addr;
      req_wdata = {NB{tbl[i].word}};
      tbl_has   = !tbl[i].we;
      tbl_exp   = {NB{tbl[i].exp}};
      step();
    end
    tbl_has = 0;
    idle(4);

    // Random traffic against the array/queue reference.
    gap = 0;
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0) || (gap >= 6);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = 5'($urandom_range(0, 31));
      for (int k = 0; k < NB; k++) req_wdata[k*32 +: 32] = $urandom();
      gap = req_valid ? 0 : gap + 1;
      step();
    end
    idle(4);

    // Deep sleep requested right behind a read: the read must finish first.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5; acc_cyc = cyc;
    step();
    req_valid = 1'b0; sleep_req = 1'b1; exp_rdy = 0;
    for (int i = 0; i < 20 && pwr_state != 3'd2; i++) step();
    chk("ds_entered", 64'(pwr_state), 64'd2);
    chk("ds_after_rsp", 64'(last_rsp_cyc == acc_cyc + 3 && last_rsp_cyc < cyc), 64'd1);
    chk("ds_pins", 64'({mem_LS, mem_CE, mem_DS, mem_SD}), 64'(4'b0010));
    sleep_req = 1'b0;
    step();
    n = 0;
    while (pwr_state == 3'd4 && n < 100) begin step(); n++; end
    chk("ds_wake_cycles", 64'(n), 64'd8);
    chk("ds_back_active", 64'(pwr_state), 64'd0);
    exp_rdy = 1;
    idle(2);

    // Shutdown overriding deep sleep.
    sleep_req = 1'b1; exp_rdy = 0;
    for (int i = 0; i < 20 && pwr_state != 3'd2; i++) step();
    chk("sd_pre_ds", 64'(pwr_state), 64'd2);
    shutdown_req = 1'b1;
    step();
    chk("sd_state", 64'(pwr_state), 64'd3);
    chk("sd_pins", 64'({mem_LS, mem_CE, mem_DS, mem_SD}), 64'(4'b0001));
    sleep_req = 1'b0; shutdown_req = 1'b0;
    step();
    n = 0;
    while (pwr_state == 3'd4 && n < 100) begin step(); n++; end
    chk("sd_wake_cycles", 64'(n), 64'd32);
    chk("sd_back_active", 64'(pwr_state), 64'd0);
    exp_rdy = 1;
    idle(2);

    // Reset one cycle after a read acceptance discards the read.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd3;
    step();
    do_reset(1);
    check_reset_vals();
    idle(6);

    // Reset while in deep sleep returns straight to ACTIVE.
    sleep_req = 1'b1; exp_rdy = 0;
    for (int i = 0; i < 20 && pwr_state != 3'd2; i++) step();
    chk("rs_pre_ds", 64'(pwr_state), 64'd2);
    do_reset(1);
    check_reset_vals();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lp_dmem_ctrl.md
LP_DMEM_CTRL -- requirements
Module: lp_dmem_ctrl

Interface
REQ-001 SHALL have parameter NUM_BANK, default 48, giving the number of 32-bit banks (data width DW = 32*NUM_BANK).
REQ-002 SHALL have parameter IDLE_CYC, default 16, giving idle cycles before light-sleep entry.
REQ-003 SHALL have parameter LS_WAKE, default 2, giving light-sleep exit cycles.
REQ-004 SHALL have parameter DS_WAKE, default 8, giving deep-sleep exit cycles.
REQ-005 SHALL have parameter SD_WAKE, default 32, giving shutdown exit cycles.
REQ-006 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req_valid  in  1  access request.
REQ-009 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-010 req_we  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  5  word address.
REQ-012 req_wdata  in  DW  write data.
REQ-013 rsp_valid  out  1  one-cycle read-data strobe (no backpressure).
REQ-014 rsp_rdata  out  DW  read data.
REQ-015 sleep_req  in  1  level request for deep sleep.
REQ-016 shutdown_req  in  1  level request for shutdown; overrides sleep_req.
REQ-017 pwr_state  out  3  0 ACTIVE, 1 LSLEEP, 2 DSLEEP, 3 SHUTDN, 4 WAKE.
REQ-018 mem_SD, mem_CE, mem_WEB, mem_OEB, mem_CSB, mem_DS, mem_LS  out  1 each  macro port controls.
REQ-019 mem_A  out  5  macro address; mem_I  out  DW  macro write data; mem_O  in  DW  macro read data.

Function
REQ-020 All mem_* outputs, rsp_valid, rsp_rdata and pwr_state SHALL be registered.
REQ-021 req_ready SHALL be 1 only in ACTIVE with sleep_req=0 and shutdown_req=0.
REQ-022 A request accepted in cycle t SHALL drive mem_CSB=0, mem_A=req_addr and mem_WEB=~req_we in cycle t+1. For writes, mem_I=req_wdata and mem_OEB=1. For reads, mem_OEB=0.
REQ-023 Without an access, the controller SHALL hold mem_CSB=1, mem_WEB=1 and mem_OEB=1; mem_A and mem_I SHALL retain their last values.
REQ-024 For a read accepted in cycle t, mem_O SHALL be sampled at the end of t+2, and the controller SHALL assert rsp_valid=1 with rsp_rdata in cycle t+3. Back-to-back reads SHALL give one response per cycle, in order.
REQ-025 Writes SHALL produce no response.
REQ-026 An idle counter SHALL count ACTIVE cycles with no accepted request and an empty pipeline. Any accepted request SHALL clear it.
REQ-027 When the idle count reaches IDLE_CYC, the FSM SHALL go ACTIVE->LSLEEP. If a request arrives in that same cycle, the request SHALL win and the counter SHALL clear.
REQ-028 In ACTIVE, when sleep_req=1 or shutdown_req=1 and the 3-stage access pipeline is empty, the FSM SHALL go to DSLEEP or SHUTDN respectively, with shutdown taking priority. While in-flight reads remain, it SHALL wait until they drain.
REQ-029 The FSM SHALL go LSLEEP->WAKE on req_valid=1, on sleep_req=1 or on shutdown_req=1. The latter two SHALL pass through WAKE and ACTIVE before entering the requested sleep state.
REQ-030 The FSM SHALL go DSLEEP->WAKE when sleep_req=0 and shutdown_req=0. It SHALL go DSLEEP->SHUTDN on shutdown_req=1.
REQ-031 The FSM SHALL go SHUTDN->WAKE when shutdown_req=0.
REQ-032 WAKE SHALL load a down-counter with LS_WAKE, DS_WAKE or SD_WAKE according to the exited state. The FSM SHALL return to ACTIVE when the counter reaches 0, and the idle counter SHALL clear on that entry.
REQ-033 Macro control outputs per state: mem_LS=1 only in LSLEEP; mem_DS=1 only in DSLEEP; mem_SD=1 only in SHUTDN.
REQ-034 mem_CE SHALL be 1 in ACTIVE and 0 in all other states.
REQ-035 mem_CSB SHALL be 1 in every non-ACTIVE state.
REQ-036 In WAKE, mem_LS, mem_DS and mem_SD SHALL all be 0.
REQ-037 No request SHALL be accepted outside ACTIVE, and rsp_valid SHALL never assert without a prior accepted read.

Reset
REQ-038 While rst=1, the controller SHALL set pwr_state=ACTIVE; mem_CSB=1, mem_WEB=1, mem_OEB=1, mem_CE=1; mem_SD=0, mem_DS=0, mem_LS=0; mem_A=0, mem_I=0; rsp_valid=0, rsp_rdata=0; and clear the idle and wake counters.
REQ-039 Reset asserted mid-operation SHALL discard in-flight reads, with no rsp_valid after reset. Reset asserted in any sleep state SHALL force ACTIVE on the next edge.
REQ-040 req_ready SHALL be 0 during the reset cycle.

Verification
REQ-041 Write addr 5 data 0xA5A5A5A5 in every bank, then read addr 5 -> rsp_valid exactly 3 cycles after read acceptance, rsp_rdata all banks 0xA5A5A5A5.
REQ-042 Reads to addresses 0,1,2 on consecutive cycles -> three consecutive rsp_valid pulses, data in address order.
REQ-043 No requests for 16 cycles -> pwr_state=1 and mem_LS=1. Then req_valid=1 -> WAKE for 2 cycles, ACTIVE, request accepted, mem_LS=0.
REQ-044 sleep_req=1 issued 1 cycle after a read acceptance -> the read response is delivered first, then DSLEEP. Deassert sleep_req -> 8 WAKE cycles, then ACTIVE.
REQ-045 shutdown_req=1 while in DSLEEP -> SHUTDN with mem_SD=1 and mem_DS=0. Release -> 32 WAKE cycles.
REQ-046 rst pulsed 1 cycle after a read acceptance -> no rsp_valid, all REQ-038 values observed.
